// File: rtl/status_scoreboard.sv
// Multi-channel result scoreboard: captures expected words at launch, records the
// first observation per enabled channel, and reports pass/fail totals or a timeout.
module status_scoreboard #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1000,
  parameter int CW      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*DATA_W-1:0] exp_data,
  input  logic [NUM_CH-1:0]        obs_valid,
  input  logic [NUM_CH*DATA_W-1:0] obs_data,
  output logic                     busy,
  output logic                     finish,
  output logic [CW-1:0]            pass_cnt,
  output logic [CW-1:0]            fail_cnt,
  output logic [NUM_CH-1:0]        fail_mask,
  output logic                     timed_out
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [CW-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + {{(CW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  state_t                     r_state;
  logic                       r_start_q;
  logic [NUM_CH-1:0]          r_en;
  logic [NUM_CH*DATA_W-1:0]   r_exp;
  logic [NUM_CH-1:0]          r_done;
  logic [TW-1:0]              r_timer;
  logic [CW-1:0]              r_pass;
  logic [CW-1:0]              r_fail;
  logic [NUM_CH-1:0]          r_mask;
  logic                       r_tout;
  logic                       r_busy;
  logic                       r_finish;

  state_t                     w_state_nxt;
  logic [NUM_CH-1:0]          w_en_nxt;
  logic [NUM_CH*DATA_W-1:0]   w_exp_nxt;
  logic [NUM_CH-1:0]          w_done_nxt;
  logic [TW-1:0]              w_timer_nxt;
  logic [CW-1:0]              w_pass_nxt;
  logic [CW-1:0]              w_fail_nxt;
  logic [NUM_CH-1:0]          w_mask_nxt;
  logic                       w_tout_nxt;

  logic                       w_launch;
  logic [NUM_CH-1:0]          w_match;
  logic [NUM_CH-1:0]          w_hit;
  logic [NUM_CH-1:0]          w_done_upd;
  logic [NUM_CH-1:0]          w_left;
  logic [NUM_CH-1:0]          w_bad;

  assign w_launch   = start & ~r_start_q;
  assign w_hit      = (r_state == S_RUN) ? (r_en & ~r_done & obs_valid) : '0;
  assign w_done_upd = r_done | w_hit;
  assign w_left     = r_en & ~w_done_upd;
  assign w_bad      = w_hit & ~w_match;

  // Per-channel word comparison against the captured expected value
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_match[i] = (obs_data[i*DATA_W +: DATA_W] == r_exp[i*DATA_W +: DATA_W]);
    end
  end

  // Next-state and next-result computation
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_exp_nxt   = r_exp;
    w_done_nxt  = r_done;
    w_timer_nxt = r_timer;
    w_pass_nxt  = r_pass;
    w_fail_nxt  = r_fail;
    w_mask_nxt  = r_mask;
    w_tout_nxt  = r_tout;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_launch) begin
          w_en_nxt    = ch_en;
          w_exp_nxt   = exp_data;
          w_done_nxt  = '0;
          w_timer_nxt = '0;
          w_pass_nxt  = '0;
          w_fail_nxt  = '0;
          w_mask_nxt  = '0;
          w_tout_nxt  = 1'b0;
          if (ch_en == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        w_timer_nxt = r_timer + TW'(1);
        w_done_nxt  = w_done_upd;
        w_pass_nxt  = r_pass + popcount(w_hit & w_match);
        w_fail_nxt  = r_fail + popcount(w_bad);
        w_mask_nxt  = r_mask | w_bad;
        // Completion takes priority over the timeout in the same cycle
        if (w_left == '0) begin
          w_state_nxt = S_DONE;
        end else if (r_timer == T_LAST) begin
          w_state_nxt = S_DONE;
          w_tout_nxt  = 1'b1;
          w_fail_nxt  = r_fail + popcount(w_bad) + popcount(w_left);
          w_mask_nxt  = r_mask | w_bad | w_left;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_en      <= '0;
      r_exp     <= '0;
      r_done    <= '0;
      r_timer   <= '0;
      r_pass    <= '0;
      r_fail    <= '0;
      r_mask    <= '0;
      r_tout    <= 1'b0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start;
      r_en      <= w_en_nxt;
      r_exp     <= w_exp_nxt;
      r_done    <= w_done_nxt;
      r_timer   <= w_timer_nxt;
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_mask    <= w_mask_nxt;
      r_tout    <= w_tout_nxt;
      r_busy    <= (w_state_nxt == S_RUN);
      r_finish  <= (w_state_nxt == S_DONE);
    end
  end

  assign busy      = r_busy;
  assign finish    = r_finish;
  assign pass_cnt  = r_pass;
  assign fail_cnt  = r_fail;
  assign fail_mask = r_mask;
  assign timed_out = r_tout;

endmodule

// File: tb/tb_status_scoreboard.sv
// Directed bench for status_scoreboard with a per-channel outcome model checked every cycle.
module tb_status_scoreboard;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int CW      = 8;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH*DATA_W-1:0] exp_data;
  logic [NUM_CH-1:0]        obs_valid;
  logic [NUM_CH*DATA_W-1:0] obs_data;
  logic                     busy;
  logic                     finish;
  logic [CW-1:0]            pass_cnt;
  logic [CW-1:0]            fail_cnt;
  logic [NUM_CH-1:0]        fail_mask;
  logic                     timed_out;

  status_scoreboard #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .exp_data(exp_data),
    .obs_valid(obs_valid), .obs_data(obs_data), .busy(busy), .finish(finish),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_mask(fail_mask), .timed_out(timed_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // Model: outcome per channel (0 pending, 1 matched, 2 mismatched, 3 timed out)
  bit          m_running = 1'b0;
  bit          m_finished = 1'b0;
  bit          m_tout = 1'b0;
  bit          m_prev = 1'b0;
  int          m_rc = 0;
  int          m_res [NUM_CH];
  logic [NUM_CH-1:0] m_en = '0;
  logic [DATA_W-1:0] m_exp [NUM_CH];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int m_pass();
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_res[i] == 1) n++;
    return n;
  endfunction

  function automatic int m_fail();
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_res[i] >= 2) n++;
    return n;
  endfunction

  function automatic logic [NUM_CH-1:0] m_mask();
    logic [NUM_CH-1:0] m = '0;
    for (int i = 0; i < NUM_CH; i++) if (m_res[i] >= 2) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_res[i] = 0;
      m_exp[i] = '0;
    end
    forever begin
      bit launch;
      bit all_done;
      @(posedge clk);
      if (rst) begin
        m_running = 1'b0; m_finished = 1'b0; m_tout = 1'b0; m_prev = 1'b0; m_rc = 0;
        for (int i = 0; i < NUM_CH; i++) m_res[i] = 0;
      end else begin
        launch = start && !m_prev;
        m_prev = start;
        if (m_running) begin
          m_rc++;
          all_done = 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (m_en[i] && m_res[i] == 0 && obs_valid[i])
              m_res[i] = (obs_data[i*DATA_W +: DATA_W] == m_exp[i]) ? 1 : 2;
            if (m_en[i] && m_res[i] == 0) all_done = 1'b0;
          end
          if (all_done) begin
            m_running = 1'b0; m_finished = 1'b1;
          end else if (m_rc == TIMEOUT) begin
            m_running = 1'b0; m_finished = 1'b1; m_tout = 1'b1;
            for (int i = 0; i < NUM_CH; i++) if (m_en[i] && m_res[i] == 0) m_res[i] = 3;
          end
        end else if (launch) begin
          m_en = ch_en;
          for (int i = 0; i < NUM_CH; i++) begin
            m_exp[i] = exp_data[i*DATA_W +: DATA_W];
            m_res[i] = 0;
          end
          m_tout = 1'b0;
          m_rc = 0;
          m_running = (ch_en != '0);
          m_finished = (ch_en == '0);
        end
      end
    end
  end

  // Compare process on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("busy", 64'(busy), 64'(m_running));
        check("finish", 64'(finish), 64'(m_finished));
        check("pass_cnt", 64'(pass_cnt), 64'(m_pass()));
        check("fail_cnt", 64'(fail_cnt), 64'(m_fail()));
        check("fail_mask", 64'(fail_mask), 64'(m_mask()));
        check("timed_out", 64'(timed_out), 64'(m_tout));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obs(input logic [NUM_CH-1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3);
    obs_valid = v;
    obs_data  = {d3, d2, d1, d0};
    tick();
    obs_valid = '0;
  endtask

  task automatic set_exp(input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    exp_data = {e3, e2, e1, e0};
  endtask

  task automatic lit(input string name, input bit b, input bit f, input int p, input int fc,
                     input logic [3:0] mk, input bit to);
    check({name, ".busy"}, 64'(busy), 64'(b));
    check({name, ".finish"}, 64'(finish), 64'(f));
    check({name, ".pass"}, 64'(pass_cnt), 64'(p));
    check({name, ".fail"}, 64'(fail_cnt), 64'(fc));
    check({name, ".mask"}, 64'(fail_mask), 64'(mk));
    check({name, ".tout"}, 64'(timed_out), 64'(to));
    check({name, ".model_pass"}, 64'(m_pass()), 64'(p));
    check({name, ".model_fail"}, 64'(m_fail()), 64'(fc));
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; ch_en = '0; exp_data = '0; obs_valid = '0; obs_data = '0;
    tick();
    chk_on = 1'b1;
    tick();
    lit("reset", 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);

    // start held through reset release launches; empty enable goes straight to DONE
    rst = 1'b0;
    tick();
    lit("empty_launch", 1'b0, 1'b1, 0, 0, 4'h0, 1'b0);

    // all four channels match, last observation two cycles after the others
    start = 1'b0; tick();
    ch_en = 4'hF; set_exp(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    start = 1'b1; tick(); start = 1'b0;
    lit("all_launch", 1'b1, 1'b0, 0, 0, 4'h0, 1'b0);
    obs(4'b0001, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
    obs(4'b0110, 32'h0, 32'h1234_5678, 32'h1234_5678, 32'h0);
    tick();
    lit("all_mid", 1'b1, 1'b0, 3, 0, 4'h0, 1'b0);
    obs(4'b1000, 32'h0, 32'h0, 32'h0, 32'h1234_5678);
    lit("all_done", 1'b0, 1'b1, 4, 0, 4'h0, 1'b0);
    tick(); tick();
    lit("all_hold", 1'b0, 1'b1, 4, 0, 4'h0, 1'b0);

    // sparse enable: disabled strobes and repeat observations ignored
    ch_en = 4'h5; set_exp(32'hA5A5_0001, 32'h1111, 32'h0, 32'h2222);
    start = 1'b1; tick(); start = 1'b0;
    obs(4'b1011, 32'hA5A5_0001, 32'hFFFF, 32'h0, 32'h0);
    lit("sparse_mid", 1'b1, 1'b0, 1, 0, 4'h0, 1'b0);
    obs(4'b0101, 32'hBAD0_BAD0, 32'h0, 32'hDEAD_BEEF, 32'h0);
    lit("sparse_done", 1'b0, 1'b1, 1, 1, 4'h4, 1'b0);

    // timeout after 16 RUN cycles with ch1 never observed
    ch_en = 4'h3; set_exp(32'hCAFE_0000, 32'hCAFE_0001, 32'h0, 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    obs(4'b0001, 32'hCAFE_0000, 32'h0, 32'h0, 32'h0);
    repeat (14) tick();
    lit("tmo_before", 1'b1, 1'b0, 1, 0, 4'h0, 1'b0);
    tick();
    lit("tmo_done", 1'b0, 1'b1, 1, 1, 4'h2, 1'b1);

    // last channel arrives on the 16th RUN cycle: completion wins
    start = 1'b1; tick(); start = 1'b0;
    obs(4'b0001, 32'hCAFE_0000, 32'h0, 32'h0, 32'h0);
    repeat (14) tick();
    obs(4'b0010, 32'h0, 32'hCAFE_0001, 32'h0, 32'h0);
    lit("edge_done", 1'b0, 1'b1, 2, 0, 4'h0, 1'b0);

    // reset mid-run aborts, then a fresh run with mixed results in one cycle
    ch_en = 4'hF; set_exp(32'h10, 32'h20, 32'h30, 32'h40);
    start = 1'b1; tick(); start = 1'b0;
    obs(4'b0001, 32'h10, 32'h0, 32'h0, 32'h0);
    lit("abort_mid", 1'b1, 1'b0, 1, 0, 4'h0, 1'b0);
    rst = 1'b1; tick();
    lit("abort_rst", 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
    rst = 1'b0; tick();
    lit("abort_idle", 1'b0, 1'b0, 0, 0, 4'h0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    obs(4'hF, 32'h10, 32'h21, 32'h30, 32'h41);
    lit("fresh_done", 1'b0, 1'b1, 2, 2, 4'hA, 1'b0);

    // relaunch from DONE clears results; second edge during RUN is ignored
    tick();
    ch_en = 4'hF; set_exp(32'h55, 32'h66, 32'h77, 32'h88);
    start = 1'b1; tick();
    lit("relaunch", 1'b1, 1'b0, 0, 0, 4'h0, 1'b0);
    start = 1'b0; tick();
    ch_en = 4'h0; set_exp(32'h0, 32'h0, 32'h0, 32'h0);
    start = 1'b1; tick();
    lit("ignored_edge", 1'b1, 1'b0, 0, 0, 4'h0, 1'b0);
    start = 1'b0;
    obs(4'hF, 32'h55, 32'h66, 32'h77, 32'h88);
    lit("relaunch_done", 1'b0, 1'b1, 4, 0, 4'h0, 1'b0);
    tick();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/status_scoreboard.md
STATUS_SCOREBOARD -- requirements
Module: status_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  NUM_CH   4    number of independent check channels
  DATA_W   32   width of each observed/expected word
  TIMEOUT  1000 max RUN cycles before forced completion
  CW       8    width of pass/fail counters
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
  clk        in   1              single clock, rising edge
  rst        in   1              synchronous, active-high reset
  start      in   1              level; rising edge launches a run
  ch_en      in   NUM_CH         channel enable, sampled at launch
  exp_data   in   NUM_CH*DATA_W  expected words, ch i at [i*DATA_W +: DATA_W], sampled at launch
  obs_valid  in   NUM_CH         per-channel observation strobe
  obs_data   in   NUM_CH*DATA_W  observed words, same packing
  busy       out  1              high in RUN
  finish     out  1              high in DONE
  pass_cnt   out  CW             channels matched
  fail_cnt   out  CW             channels mismatched or timed out
  fail_mask  out  NUM_CH         bit i set = channel i failed
  timed_out  out  1              run ended by TIMEOUT

Function
REQ-003 FSM SHALL have states IDLE, RUN and DONE, all registered on clk.
REQ-004 Launch edge SHALL be detected as start & ~start_q, where start_q is start registered one cycle.
REQ-005 A launch edge in IDLE or DONE SHALL capture ch_en and exp_data, clear counters, fail_mask, timed_out, per-channel done flags and timer, and enter RUN next cycle.
REQ-006 A launch edge with ch_en == 0 SHALL go directly to DONE with all counts 0.
REQ-007 A launch edge while in RUN SHALL be ignored.
REQ-008 In RUN, enabled, not-done channel i with obs_valid[i]=1 SHALL set done[i] and compare obs_data word i against its captured expected word.
REQ-009 On a match, pass_cnt SHALL increment; on a mismatch, fail_cnt SHALL increment and fail_mask[i] SHALL set.
REQ-010 Several channels completing in one cycle SHALL add their pass/fail popcounts in that same cycle.
REQ-011 obs_valid on a disabled or already-done channel SHALL be ignored; only the first observation counts.
REQ-012 The timer SHALL increment each RUN cycle.
REQ-013 When all enabled channels are done, including those completing this cycle, FSM SHALL enter DONE next cycle (finish one cycle after last observation).
REQ-014 When the timer equals TIMEOUT-1 and enabled channels remain undone, FSM SHALL enter DONE with timed_out=1, each undone enabled channel added to fail_cnt and fail_mask.
REQ-015 If the last channel completes in the same cycle the timer hits the limit, completion SHALL win: timed_out=0, no extra failures.
REQ-016 In DONE, all result outputs SHALL hold stable until the next launch edge or rst.
REQ-017 Counters SHALL use CW bits; NUM_CH SHALL be ≤ 2^CW-1, so counters never wrap.
REQ-018 busy and finish SHALL never be high simultaneously.

Reset
REQ-019 rst=1 at a rising clk edge SHALL force IDLE and clear start_q, busy, finish, pass_cnt, fail_cnt, fail_mask, timed_out, timer and done flags to 0.
REQ-020 rst asserted mid-RUN SHALL abort the run without asserting finish.
REQ-021 start already high when rst releases SHALL count as a launch edge on the first cycle after release.

Verification (NUM_CH=4, DATA_W=32, TIMEOUT=16, CW=8)
REQ-022 ch_en=4'hF, all exp=32'h1234_5678, matching obs on ch0..3 at cycles 2,3,3,5 -> finish at cycle 6, pass_cnt=4, fail_cnt=0, fail_mask=0, timed_out=0.
REQ-023 ch_en=4'h5, ch2 obs=32'hDEAD_BEEF vs exp 32'h0, ch0 match, ch1/ch3 strobes also driven -> pass_cnt=1, fail_cnt=1, fail_mask=4'h4.
REQ-024 ch_en=4'h3, only ch0 observes (match) -> DONE after 16 RUN cycles, timed_out=1, pass_cnt=1, fail_cnt=1, fail_mask=4'h2.
REQ-025 Final channel observes in the 16th RUN cycle -> timed_out=0, no timeout failure counted.
REQ-026 rst pulsed mid-RUN, then start re-raised -> all outputs 0 after rst, fresh run completes normally.
REQ-027 From DONE, start toggled low then high -> outputs clear and a new run proceeds; a second edge during RUN has no effect.
